// File: rtl/hazard_control.sv
// Pipeline hazard controller: destination tracker for EX/MEM/WB, load-use stall,
// branch flush and a RUN/MEM_WAIT FSM for slow loads. Optional STALL_CNT_EN adds a stall counter.
module hazard_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_valid,
  input  logic        ex_branch_taken,
  input  logic        mem_ready,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [4:0]  ex_rd,
  output logic [4:0]  mem_rd,
  output logic [4:0]  wb_rd,
  output logic        ex_regwrite,
  output logic        mem_regwrite,
  output logic        wb_regwrite,
  output logic        mem_memtoreg
`ifdef STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       valid;
  } trk_t;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0] state, state_nxt;
  trk_t       ex_q, mem_q, wb_q, id_e;
  logic       in_run, mem_pending, branch_flush, load_use;

  assign id_e = '{rd: id_rd, regwrite: id_regwrite, memread: id_memread, valid: id_valid};

  assign in_run       = (state == RUN);
  // A load sitting in MEM without its data freezes EX/MEM, in RUN as well as in MEM_WAIT.
  assign mem_pending  = mem_q.valid & mem_q.memread & ~mem_ready;
  assign branch_flush = in_run & ex_branch_taken;
  assign load_use     = in_run & ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_valid &
                        ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    if (!reset) begin
      if (state == MEM_WAIT) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
      end else if (branch_flush) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_pending) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready)   state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      state <= state_nxt;
      if (mem_pending) begin
        wb_q <= '0;
      end else begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= (branch_flush | load_use) ? '0 : id_e;
      end
    end
  end

  // x0 is never a forwarding source, so its regwrite is masked here.
  assign ex_rd        = ex_q.rd;
  assign mem_rd       = mem_q.rd;
  assign wb_rd        = wb_q.rd;
  assign ex_regwrite  = ~reset & ex_q.regwrite  & ex_q.valid  & (ex_q.rd  != 5'd0);
  assign mem_regwrite = ~reset & mem_q.regwrite & mem_q.valid & (mem_q.rd != 5'd0);
  assign wb_regwrite  = ~reset & wb_q.regwrite  & wb_q.valid  & (wb_q.rd  != 5'd0);
  assign mem_memtoreg = ~reset & mem_q.memread  & mem_q.valid;

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= 16'd0;
    else if (stall_pc && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have inputs id_rs1 and id_rs2, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have inputs id_rd (5 bits), id_regwrite (1), id_memread (1) and id_valid (1): destination-register info of the instruction in ID.
REQ-005 SHALL have input ex_branch_taken, 1 bit: branch/jump resolved taken in EX this cycle.
REQ-006 SHALL have input mem_ready, 1 bit: data memory has completed the access for the load in MEM.
REQ-007 SHALL have outputs stall_pc, stall_ifid, stall_idex and stall_exmem, 1 bit each: hold the corresponding pipeline register.
REQ-008 SHALL have outputs flush_ifid and flush_idex, 1 bit each: load a bubble into the corresponding pipeline register.
REQ-009 SHALL have outputs ex_rd, mem_rd, wb_rd (5 bits each), and ex_regwrite, mem_regwrite, wb_regwrite, mem_memtoreg (1 bit each): tracked destination info that drives the forwarding unit.
REQ-010 SHALL have output stall_count, 16 bits, only when STALL_CNT_EN is defined.

Function
REQ-011 SHALL keep a three-entry tracker {rd, regwrite, memread, valid} for the EX, MEM and WB stages; on each advancing cycle ID->EX->MEM->WB.
REQ-012 SHALL drive the regwrite outputs as (stored regwrite AND valid), and mem_memtoreg as (MEM memread AND valid).
REQ-013 SHALL implement FSM states RUN and MEM_WAIT.
REQ-014 SHALL, in RUN, move to MEM_WAIT at the next edge when the MEM entry is a valid load and mem_ready=0.
REQ-015 SHALL, in MEM_WAIT, assert all four stall outputs and hold the EX and MEM entries; WB SHALL receive a bubble each cycle (valid=0).
REQ-016 SHALL return from MEM_WAIT to RUN at the edge on which mem_ready=1; the load then advances to WB on that same edge.
REQ-017 SHALL detect load-use combinationally in RUN: EX entry valid AND memread AND ex_rd!=0 AND (ex_rd==id_rs1 OR ex_rd==id_rs2) AND id_valid.
REQ-018 SHALL, on load-use, assert stall_pc and stall_ifid for that cycle; EX receives a bubble while EX->MEM->WB advance, giving exactly one bubble per hazard.
REQ-019 SHALL, on ex_branch_taken=1 in RUN, assert flush_ifid and flush_idex for that cycle; the EX entry's valid is loaded from ID as 0.
REQ-020 SHALL apply priority MEM_WAIT > branch flush > load-use; a branch flush suppresses a simultaneous load-use stall.
REQ-021 SHALL generate stall/flush outputs combinationally from state and current inputs; the tracker and FSM are registered.
REQ-022 SHALL treat rd==0 as never hazardous and never forwarded (its regwrite output is forced to 0).

Reset
REQ-023 SHALL, on reset=1, clear all tracker entries (rd=0, valid=0), set state RUN and clear stall_count, independently of clk.
REQ-024 SHALL drive all stall, flush and regwrite outputs to 0 while reset is asserted; reset mid-MEM_WAIT discards the pending load.

Configuration
REQ-025 SHALL, with STALL_CNT_EN defined, increment stall_count (saturating at 16'hFFFF) on every cycle in which stall_pc=1.
REQ-026 SHALL, without STALL_CNT_EN, omit stall_count and its logic entirely, with all other behaviour unchanged.

Verification
REQ-027 Load x5 into EX, ID reads rs1=5 -> stall_pc=stall_ifid=1 for exactly 1 cycle; next cycle mem_rd=5, mem_memtoreg=1, ex_regwrite=0.
REQ-028 Load x5 into EX, ID rs1=rs2=0 with rd=0 load -> no stall.
REQ-029 Load in MEM with mem_ready low for 3 cycles -> all stalls high 3 cycles, wb_regwrite=0 during the wait, then wb_rd=load rd.
REQ-030 ex_branch_taken=1 together with a load-use condition -> flush_ifid=flush_idex=1 and stall_pc=0 in that cycle.
REQ-031 Assert reset during MEM_WAIT -> all outputs 0 immediately, state RUN after release, stall_count=0.
REQ-032 With STALL_CNT_EN: two load-use hazards plus a 3-cycle MEM_WAIT -> stall_count=5.
